// File: rtl/sys_row_dbw.sv
// Weight-stationary systolic row with double-buffered weights. Shadow weights load
// through a serial chain while compute runs; a skewed swap token promotes them per column.
module sys_row_dbw #(
  parameter int  SYS_COL    = 16,
  parameter int  DATA_WIDTH = 16,
  parameter bit  SATURATE   = 1'b0,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 en_in,
  input  logic [DATA_WIDTH-1:0]                in,
  input  logic                                 w_swap_in,
  input  logic                                 w_load_valid,
  input  logic [DATA_WIDTH-1:0]                w_load_data,
  output logic                                 w_load_ready,
  output logic                                 w_full,
  input  logic [SYS_COL-1:0][PSUM_WIDTH-1:0]   psum_in,
  output logic [SYS_COL-1:0][PSUM_WIDTH-1:0]   psum_out,
  output logic [SYS_COL-1:0]                   psum_valid,
  output logic                                 en_out,
  output logic [DATA_WIDTH-1:0]                pass_out,
  output logic                                 w_swap_out
);

  localparam int CNT_W = $clog2(SYS_COL + 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(SYS_COL);
  localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

  logic [SYS_COL-1:0]                  r_en_q;
  logic [SYS_COL-1:0]                  r_swap_q;
  logic [SYS_COL-1:0]                  r_psum_valid;
  logic [SYS_COL-1:0][DATA_WIDTH-1:0]  r_act_q;
  logic [SYS_COL-1:0][DATA_WIDTH-1:0]  r_shadow_w;
  logic [SYS_COL-1:0][DATA_WIDTH-1:0]  r_active_w;
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0]  r_psum;
  logic [CNT_W-1:0]                    r_load_cnt;

  logic [SYS_COL-1:0]                  w_col_en;
  logic [SYS_COL-1:0]                  w_col_swap;
  logic [SYS_COL-1:0][DATA_WIDTH-1:0]  w_col_act;
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0]  w_prod;
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0]  w_raw;
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0]  w_sum;
  logic [SYS_COL-1:0]                  w_ovf;
  logic                                w_accept;

  assign w_col_en   = {r_en_q[SYS_COL-2:0], en_in};
  assign w_col_swap = {r_swap_q[SYS_COL-2:0], w_swap_in};
  assign w_col_act  = {r_act_q[SYS_COL-2:0], in};

  // Shadows stay frozen until the swap token has been consumed by the last column.
  assign w_load_ready = !w_swap_in && !(|r_swap_q[SYS_COL-2:0]);
  assign w_accept     = w_load_valid && w_load_ready;
  assign w_full       = (r_load_cnt == CNT_FULL);

  always_comb begin
    w_prod = '0;
    w_raw  = '0;
    w_sum  = '0;
    w_ovf  = '0;
    for (int i = 0; i < SYS_COL; i++) begin
      w_prod[i] = $signed({{DATA_WIDTH{w_col_act[i][DATA_WIDTH-1]}}, w_col_act[i]}) *
                  $signed({{DATA_WIDTH{r_active_w[i][DATA_WIDTH-1]}}, r_active_w[i]});
      w_raw[i]  = psum_in[i] + w_prod[i];
      // Overflow only when both operands share a sign that the result lost.
      w_ovf[i]  = (psum_in[i][PSUM_WIDTH-1] == w_prod[i][PSUM_WIDTH-1]) &&
                  (w_raw[i][PSUM_WIDTH-1] != psum_in[i][PSUM_WIDTH-1]);
      if (SATURATE && w_ovf[i]) begin
        w_sum[i] = psum_in[i][PSUM_WIDTH-1] ? PSUM_MIN : PSUM_MAX;
      end else begin
        w_sum[i] = w_raw[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en_q       <= '0;
      r_swap_q     <= '0;
      r_psum_valid <= '0;
      r_act_q      <= '0;
      r_shadow_w   <= '0;
      r_active_w   <= '0;
      r_psum       <= '0;
      r_load_cnt   <= '0;
    end else begin
      r_act_q      <= w_col_act;
      r_en_q       <= w_col_en;
      r_swap_q     <= w_col_swap;
      r_psum_valid <= w_col_en;
      for (int i = 0; i < SYS_COL; i++) begin
        if (w_col_swap[i]) r_active_w[i] <= r_shadow_w[i];
        if (w_col_en[i])   r_psum[i]     <= w_sum[i];
      end
      if (w_accept) r_shadow_w <= {r_shadow_w[SYS_COL-2:0], w_load_data};
      if (w_swap_in) begin
        r_load_cnt <= '0;
      end else if (w_accept && (r_load_cnt != CNT_FULL)) begin
        r_load_cnt <= r_load_cnt + CNT_W'(1);
      end
    end
  end

  assign psum_out   = r_psum;
  assign psum_valid = r_psum_valid;
  assign en_out     = r_en_q[SYS_COL-1];
  assign pass_out   = r_act_q[SYS_COL-1];
  assign w_swap_out = r_swap_q[SYS_COL-1];

endmodule

// File: doc/sys_row_dbw.md
Name: sys_row_dbw

Overview:
- Next-generation weight-stationary systolic row for the MMU.
- Activations enter at column 0 and ripple one column per cycle; partial sums flow vertically, one per column.
- New versus the previous row: double-buffered weights loaded through a serial shift chain while compute continues; a swap token that travels with the activation skew; a load ready/full handshake; optional saturating accumulation.
- All PE logic is self-contained; no child PE module.

Parameters:
- SYS_COL, 16, number of columns (>=2).
- DATA_WIDTH, 16, signed activation/weight width.
- PSUM_WIDTH, 2*DATA_WIDTH, localparam; signed psum width.
- SATURATE, 0, 1 = clamp psum adds to signed PSUM_WIDTH range; 0 = two's-complement wrap.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- en_in  input  1  activation valid into column 0.
- in  input  DATA_WIDTH  signed activation into column 0.
- w_swap_in  input  1  swap token into column 0.
- w_load_valid  input  1  shadow-weight word valid.
- w_load_data  input  DATA_WIDTH  shadow-weight word.
- w_load_ready  output  1  load accepted when high with w_load_valid.
- w_full  output  1  SYS_COL words loaded since last swap.
- psum_in  input  PSUM_WIDTH x SYS_COL  psum from the row above, per column.
- psum_out  output  PSUM_WIDTH x SYS_COL  registered psum, per column.
- psum_valid  output  SYS_COL  per-column psum_out valid.
- en_out  output  1  en from the last column stage.
- pass_out  output  DATA_WIDTH  activation from the last column stage.
- w_swap_out  output  1  swap token from the last column stage.

Behaviour:
- Per-column state: act_q, en_q, swap_q, shadow_w, active_w, psum_out, psum_valid. A global load_cnt ranges 0..SYS_COL.
- Reset: every register clears to 0. All outputs read 0, except w_load_ready=1. Reset can occur mid-operation; in-flight tokens, the counter and loaded weights are all lost.
- Column inputs: column 0 takes en_in/in/w_swap_in; column i>0 takes en_q[i-1]/act_q[i-1]/swap_q[i-1]. Every cycle, act_q/en_q/swap_q capture the column inputs.
- MAC: when column en is high, psum_out[i] <= psum_in[i] + act*active_w[i] (signed, full PSUM_WIDTH product) and psum_valid[i] <= 1. Otherwise psum_valid[i] <= 0 and psum_out[i] holds.
- Latency: an activation presented at cycle t computes in column i at edge t+i; psum_out[i] is valid from cycle t+i+1. Throughput is one activation per cycle.
- Swap: when the column swap input is high, active_w[i] <= shadow_w[i]. A MAC in the same cycle uses the old active_w. The new weight applies from the next activation onward, so the swap must lead the first new-set activation by at least 1 cycle.
- Load accept: accept = w_load_valid && w_load_ready. On accept:
  - shadow_w[0] <= w_load_data and shadow_w[i] <= shadow_w[i-1];
  - after SYS_COL accepts, column SYS_COL-1 holds the first word.
- Ready: w_load_ready = !w_swap_in && !(|swap_q[0..SYS_COL-2]), combinational. Shadows are therefore frozen from the swap cycle until the token has reached the last column.
- load_cnt:
  - +1 per accept, saturating at SYS_COL;
  - cleared on a w_swap_in cycle (the swap has priority; a load is impossible in that cycle);
  - w_full = (load_cnt == SYS_COL).
- Over-loading: loads after full keep shifting, the oldest word is lost, and the count stays at SYS_COL.
- Early swap: a swap while not full is legal; columns copy whatever their shadow holds.
- Back-to-back swaps: legal; each column copies its (unchanged) shadow again.
- SATURATE=1: a sum above max becomes 2^(PSUM_WIDTH-1)-1; a sum below min becomes -2^(PSUM_WIDTH-1). Detection uses sign-bit overflow of the operands versus the result.
- Outputs: en_out = en_q[SYS_COL-1], pass_out = act_q[SYS_COL-1], w_swap_out = swap_q[SYS_COL-1].

Test Plan:
- Config for all scenarios unless stated: SYS_COL=4, DATA_WIDTH=8.
- Reset check: after rstn release, all psum_out=0, psum_valid=0, w_load_ready=1, w_full=0 -> values hold with no stimulus.
- Load 1,2,3,4; pulse swap; 1 cycle later en_in=1 with in=5, psum_in all 10 -> psum_out[3..0] = 15,20,25,30, valid at cycles t+1..t+4. w_full goes high after the 4th load and clears on the swap.
- Weight overlap: with active weights 1..4 computing a stream, load 9,9,9,9 concurrently -> results are unchanged until a swap is sent, then columns switch to 9 staggered one cycle per column.
- Ready handshake: swap at cycle s -> w_load_ready=0 for cycles s..s+3. A w_load_valid held through that window is accepted at s+4, and load_cnt=1.
- Saturation: SATURATE=1, DATA_WIDTH=8, psum_in=32767, act=127, w=127 -> psum_out=32767. With SATURATE=0 -> 32767+16129 wrapped = -16640.
- Reset mid-stream with swap token at column 1 -> all state is 0 after release, and a fresh load+swap works normally.
